int_timer: RTL and testbench
============================

INT_TIMER -- requirements
Module: int_timer

Interface
REQ-001 Parameter CNT_W, default 32, counter width in bits (1..32); PRESET and COUNT SHALL read zero-extended to 32 bits.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 addr  input  2  word select within the device, byte address bits [3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-005 we  input  1  bridge write strobe, one write per cycle.
REQ-006 byteen  input  4  per-byte write enable; used only when TIMER_BYTEEN_EN is defined, otherwise ignored.
REQ-007 din  input  32  write data.
REQ-008 dout  output  32  read data, combinational from addr and current registers.
REQ-009 irq  output  1  interrupt request to the CPU's IRQ input.

Function
REQ-010 CTRL SHALL hold En=bit0, Mode=bits[2:1], IM=bit3; reads SHALL return {28'b0, IM, Mode, En}, and unused bits SHALL be write-ignored.
REQ-011 A write with we=1 SHALL take effect at the next clk edge; writes to COUNT or the reserved word SHALL be ignored; a read of the reserved word SHALL return 0.
REQ-012 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if En=1, go to LOAD.
REQ-014 LOAD: COUNT<=PRESET; go to CNT.
REQ-015 CNT: if En=0, go to IDLE with COUNT held; else if COUNT>1, COUNT<=COUNT-1; else COUNT<=0 and go to INT.
REQ-016 Result: PRESET=N>=1 SHALL spend exactly N cycles in CNT, and PRESET=0 SHALL spend 1 cycle in CNT.
REQ-017 INT: go to IDLE and set irq_flag; Mode 0 SHALL also clear En (one-shot), and Mode 1 SHALL keep En (auto-reload via IDLE->LOAD).
REQ-018 Mode values 2 and 3 SHALL behave as Mode 0.
REQ-019 Mode 0: irq_flag SHALL stay set until any write to CTRL.
REQ-020 Mode 1: irq_flag SHALL be high for exactly one cycle, the cycle after INT.
REQ-021 irq SHALL equal IM & irq_flag; clearing IM SHALL mask irq but leave irq_flag unchanged.
REQ-022 A PRESET write during CNT SHALL NOT alter the running COUNT; it applies at the next LOAD.
REQ-023 A CTRL write in the same cycle as INT clearing En SHALL win: the written En value persists and irq_flag is cleared.

Reset
REQ-024 While reset is high: state=IDLE, CTRL=0, PRESET=0, COUNT=0, irq_flag=0, irq=0, and dout SHALL reflect the zeroed registers.
REQ-025 Reset asserted mid-count SHALL abort immediately; counting SHALL NOT resume until software sets En.

Configuration
REQ-026 With TIMER_BYTEEN_EN defined, the CTRL and PRESET writes SHALL update only the bytes whose byteen bit is set; a CTRL write with byteen[0]=0 SHALL still clear irq_flag.
REQ-027 Without TIMER_BYTEEN_EN, we=1 SHALL write the whole word and byteen SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the register-offset constants (CTRL/PRESET/COUNT), the CTRL bit positions, the mode encodings and the FSM state enum.
REQ-029 A single sub-module, int_timer_regs (register file plus byte-enable merge), is natural; the FSM and counter SHALL live in int_timer.

Verification
REQ-030 Mode 0: PRESET=5, then CTRL=0x9 -> IDLE->LOAD->CNT for 5 cycles -> INT; irq=1 from the next cycle and held; CTRL reads 0x8; a CTRL write of 0x8 drops irq.
REQ-031 Mode 1: PRESET=3, CTRL=0xB -> irq pulses 1 cycle every 6 cycles (LOAD + 3 CNT + INT + IDLE); COUNT reads reload to 3.
REQ-032 Stop mid-count: PRESET=10, En=1; after 4 CNT cycles write CTRL=0 -> IDLE; COUNT holds 6 (or the value at the write edge); no irq.
REQ-033 Boundaries: PRESET=0 -> INT after 1 CNT cycle; PRESET=0xFFFFFFFF with CNT_W=32 -> no overflow; a PRESET write during CNT leaves COUNT unchanged.
REQ-034 Reset asserted during CNT with irq_flag set -> all registers 0 and irq=0 asynchronously, before the next edge.
REQ-035 With TIMER_BYTEEN_EN, PRESET=0x11223344 then write 0xAABBCCDD with byteen=0b0101 -> PRESET reads 0x11BB33DD.

Source files
------------

// File: rtl/int_timer_pkg.sv
// Shared constants for the interrupt timer: register offsets, CTRL layout,
// mode encodings and the FSM state type.
package int_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode, input logic im);
    return {28'b0, im, mode, en};
  endfunction

endpackage

// File: rtl/int_timer_if.sv
// Bus-side signals of the interrupt timer: register access plus the irq line.
interface int_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, we, byteen, din, input dout, irq);
  modport slave  (input addr, we, byteen, din, output dout, irq);
endinterface

// File: rtl/int_timer_regs.sv
// CTRL and PRESET register file with byte-lane write merge.
// Byte enables are honoured only when TIMER_BYTEEN_EN is defined.
module int_timer_regs
  import int_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [3:0]       byteen,
  input  logic [31:0]      din,
  input  logic             clear_en,
  output logic             en,
  output logic [1:0]       mode,
  output logic             im,
  output logic [CNT_W-1:0] preset,
  output logic             ctrl_wr
);

  logic             en_reg;
  logic [1:0]       mode_reg;
  logic             im_reg;
  logic [CNT_W-1:0] preset_reg;
  logic             preset_wr;
  logic [3:0]       byte_mask;
  logic [3:0]       ctrl_merged;
  logic [31:0]      preset_word;
  logic [31:0]      preset_merged;

`ifdef TIMER_BYTEEN_EN
  assign byte_mask = byteen;
`else
  logic unused_byteen;
  assign unused_byteen = ^byteen;
  assign byte_mask     = 4'hF;
`endif

  assign ctrl_wr     = we && (addr == ADDR_CTRL);
  assign preset_wr   = we && (addr == ADDR_PRESET);
  assign preset_word = 32'(preset_reg);

  // All live CTRL bits sit in byte 0.
  assign ctrl_merged = byte_mask[0] ? din[3:0] : {im_reg, mode_reg, en_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign preset_merged[8*gi +: 8] = byte_mask[gi] ? din[8*gi +: 8] : preset_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_reg     <= 1'b0;
      mode_reg   <= MODE_ONESHOT;
      im_reg     <= 1'b0;
      preset_reg <= '0;
    end else begin
      // Software writes to CTRL override the one-shot auto-clear of En.
      if (ctrl_wr) begin
        en_reg   <= ctrl_merged[CTRL_EN_BIT];
        mode_reg <= ctrl_merged[CTRL_MODE_LSB +: 2];
        im_reg   <= ctrl_merged[CTRL_IM_BIT];
      end else if (clear_en) begin
        en_reg <= 1'b0;
      end
      if (preset_wr) begin
        preset_reg <= preset_merged[CNT_W-1:0];
      end
    end
  end

  assign en     = en_reg;
  assign mode   = mode_reg;
  assign im     = im_reg;
  assign preset = preset_reg;

endmodule

// File: rtl/int_timer.sv
// Interrupt timer top: IDLE/LOAD/CNT/INT sequencer, down-counter, irq flag
// and read mux. Optional byte-lane writes are enabled by TIMER_BYTEEN_EN.
module int_timer
  import int_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     reset,
  int_timer_if.slave bus
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             irq_flag_reg, irq_flag_next;
  logic             en, im, ctrl_wr, clear_en, int_hit;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset;

  int_timer_regs #(.CNT_W(CNT_W)) u_regs (
    .clk      (clk),
    .reset    (reset),
    .addr     (bus.addr),
    .we       (bus.we),
    .byteen   (bus.byteen),
    .din      (bus.din),
    .clear_en (clear_en),
    .en       (en),
    .mode     (mode),
    .im       (im),
    .preset   (preset),
    .ctrl_wr  (ctrl_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    clear_en   = 1'b0;
    int_hit    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (count_reg > CNT_W'(1)) begin
          count_next = count_reg - CNT_W'(1);
        end else begin
          count_next = '0;
          state_next = ST_INT;
        end
      end
      ST_INT: begin
        int_hit    = 1'b1;
        clear_en   = (mode != MODE_RELOAD);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reload mode turns the flag into a one-cycle pulse; other modes latch it.
  always_comb begin
    irq_flag_next = irq_flag_reg;
    if (ctrl_wr) begin
      irq_flag_next = 1'b0;
    end else if (int_hit) begin
      irq_flag_next = 1'b1;
    end else if (mode == MODE_RELOAD) begin
      irq_flag_next = 1'b0;
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      ADDR_CTRL:   bus.dout = ctrl_word(en, mode, im);
      ADDR_PRESET: bus.dout = 32'(preset);
      ADDR_COUNT:  bus.dout = 32'(count_reg);
      default:     bus.dout = '0;
    endcase
  end

  assign bus.irq = im & irq_flag_reg;

endmodule

// File: tb/tb_int_timer.sv
// Scoreboard bench for int_timer: a timeline model predicts dout/irq per cycle,
// a negedge monitor compares. Byte-lane cases run when TIMER_BYTEEN_EN is defined.
module tb_int_timer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_timer_if bus_if ();

  int_timer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  addr;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  // Model: register contents plus position in the current run.
  // t_run = -1 idle, 0 load cycle, 1..last counting cycles, last+1 interrupt cycle.
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  longint      t_run, n_run;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0; t_run = -1; n_run = 0;
  endtask

  task automatic model_step(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [3:0] mask;
    logic       wr_ctrl, wr_pre, fire;
    logic [1:0] mode_old;
    longint     last;
`ifdef TIMER_BYTEEN_EN
    mask = be;
`else
    mask = be | 4'hF;
`endif
    wr_ctrl  = w && (a == 2'd0);
    wr_pre   = w && (a == 2'd1);
    mode_old = m_mode;
    fire     = 0;
    last     = (n_run == 0) ? 1 : n_run;
    if (t_run < 0) begin
      if (m_en) t_run = 0;
    end else if (t_run == 0) begin
      n_run   = longint'(m_preset);
      m_count = m_preset;
      t_run   = 1;
    end else if (t_run <= last) begin
      if (!m_en) begin
        t_run = -1;
      end else begin
        m_count = (t_run == last) ? 32'd0 : 32'(n_run - t_run);
        t_run++;
      end
    end else begin
      fire  = 1;
      t_run = -1;
    end
    if (mode_old == 2'd1) m_flag = fire && !wr_ctrl;
    else                  m_flag = !wr_ctrl && (fire || m_flag);
    if (wr_ctrl) begin
      if (mask[0]) {m_im, m_mode, m_en} = d[3:0];
    end else if (fire && mode_old != 2'd1) begin
      m_en = 0;
    end
    if (wr_pre) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) m_preset[8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_cycle(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    bus_if.we     = w;
    bus_if.addr   = a;
    bus_if.din    = d;
    bus_if.byteen = be;
    e.cyc  = cyc;
    e.addr = a;
    e.dout = model_read(a);
    e.irq  = m_im & m_flag;
    exp_q.push_back(e);
    if (w) $display("wr cyc=%0d addr=%0d din=%h be=%h", cyc, a, d, be);
    @(posedge clk);
    model_step(w, a, d, be);
    cyc++;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    do_cycle(1'b1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [1:0] a);
    do_cycle(1'b0, a, 32'($urandom), 4'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(2'($urandom_range(0, 3)));
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic reset_cycle(input logic [1:0] a);
    exp_t e;
    reset = 1'b1;
    model_reset();
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    e.cyc  = cyc;
    e.addr = a;
    e.dout = 32'd0;
    e.irq  = 1'b0;
    exp_q.push_back(e);
    $display("reset cyc=%0d", cyc);
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus_if.dout === e.dout) passed++;
      else $display("FAIL dout cyc=%0d addr=%0d got=%h want=%h", e.cyc, e.addr, bus_if.dout, e.dout);
      checks++;
      if (bus_if.irq === e.irq) passed++;
      else $display("FAIL irq cyc=%0d got=%b want=%b", e.cyc, bus_if.irq, e.irq);
    end
  end

  initial begin
    reset         = 1'b1;
    bus_if.we     = 1'b0;
    bus_if.addr   = 2'd0;
    bus_if.din    = 32'd0;
    bus_if.byteen = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int a = 0; a < 4; a++) rd(2'(a));

    // One-shot with irq enabled, then clear by CTRL write.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 10; i++) rd(2'd2);
    rd(2'd0);
    idle(3);
    wr(2'd0, 32'h8);
    idle(3);

    // Auto-reload.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 0; i < 20; i++) rd(2'd2);
    wr(2'd0, 32'h0);
    idle(4);

    // Stop mid-count.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    idle(5);
    wr(2'd0, 32'h0);
    for (int i = 0; i < 5; i++) rd(2'd2);

    // Boundaries: zero preset, max preset, preset write while counting.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle(6);
    wr(2'd0, 32'h8);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 8; i++) rd(2'd2);
    wr(2'd1, 32'd7);
    for (int i = 0; i < 4; i++) rd(2'd2);
    wr(2'd0, 32'h0);
    idle(2);

    // Reset with irq latched, and reset during counting.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    idle(7);
    reset_cycle(2'd0);
    idle(4);
    wr(2'd1, 32'd20);
    wr(2'd0, 32'hB);
    idle(6);
    reset_cycle(2'd2);
    idle(5);

`ifdef TIMER_BYTEEN_EN
    wr(2'd1, 32'h1122_3344);
    do_cycle(1'b1, 2'd1, 32'hAABB_CCDD, 4'b0101);
    rd(2'd1);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    idle(5);
    do_cycle(1'b1, 2'd0, 32'h0, 4'b1110);
    idle(3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset_cycle(2'($urandom_range(0, 3)));
      end else if (r < 12) begin
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 9) < 7) v[0] = 1'b1;
        do_cycle(1'b1, 2'd0, v, 4'($urandom));
      end else if (r < 19) begin
        logic [31:0] v;
        v = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                        : 32'($urandom_range(0, 6));
        do_cycle(1'b1, 2'd1, v, 4'($urandom));
      end else if (r < 23) begin
        do_cycle(1'b1, 2'($urandom_range(2, 3)), $urandom, 4'($urandom));
      end else begin
        rd(2'($urandom_range(0, 3)));
      end
    end

    idle(2);
    bus_if.we = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got=%0d want=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
